sb_config_loader: RTL and testbench
===================================

# sb_config_loader

Programming controller for the switchbox configuration scan chain. It accepts configuration words from a host over a valid/ready handshake and serializes them MSB-first onto the daisy-chained `program_en`/`program_data` inputs of the fabric's switchboxes. When compiled in, it can also run a non-destructive recirculating readback pass and CRC-check the chain contents. It sits between the host/CSR bridge and the head of the switchbox chain.

## Interface
Parameters:
- `CHAIN_LEN`, default 256: total flop depth from `program_data_o` to `chain_tail_i`. Each switchbox slice contributes its program register width plus 1 output flop.
- `WORD_W`, default 32: width of host configuration words.

Ports (clock and reset):
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, synchronous, active-high.

Ports (host side):
- `start_i` input 1: begin a load; sampled only in IDLE.
- `word_valid_i` input 1: host word valid.
- `word_data_i` input WORD_W: configuration word.
- `word_ready_o` output 1: controller accepts the word this cycle.

Ports (chain side):
- `program_en_o` output 1: shift enable to every switchbox.
- `program_data_o` output 1: serial data into the chain head.
- `chain_tail_i` input 1: serial data out of the last switchbox.

Ports (status):
- `busy_o` output 1: high in any state other than IDLE.
- `done_o` output 1: one-cycle pulse when the sequence completes.
- `error_o` output 1: readback CRC mismatch. Sticky until the next accepted `start_i`.

## Operation
- Word count is NWORDS = ceil(CHAIN_LEN/WORD_W). The final word shifts only CHAIN_LEN − (NWORDS−1)·WORD_W bits, taken from its MSBs; its remaining LSBs are discarded.
- Bits are shifted MSB-first, word 0 first. The first bit shifted ends up farthest from the head.
- FSM states: IDLE, LOAD, SHIFT, VERIFY (macro only), DONE.
  - IDLE: on `start_i`, go to LOAD, clear `error_o`, and clear the bit and word counters.
  - LOAD: `word_ready_o`=1. On `word_valid_i`, latch the word and go to SHIFT.
  - SHIFT: one bit per cycle with `program_en_o`=1. After the word's last bit: go to LOAD if words remain; otherwise go to VERIFY (macro) or DONE.
  - VERIFY: `program_en_o`=1 for exactly CHAIN_LEN cycles, with `program_data_o` = `chain_tail_i` combinationally. This recirculates the chain, so its contents are unchanged afterwards. Go to DONE.
  - DONE: `done_o`=1 for one cycle, then go to IDLE.
- `start_i` outside IDLE is ignored. `word_valid_i` outside LOAD is ignored.
- `program_en_o`=0 in IDLE, LOAD and DONE. `program_data_o` holds 0 when not shifting.
- Bit counter width is $clog2(CHAIN_LEN+1). Word counter width is $clog2(NWORDS+1).

## Timing
- Reset value of every output is 0. The FSM resets to IDLE. `rst_i` mid-load or mid-verify aborts immediately with `program_en_o`=0 on the next cycle. Chain contents are then undefined; the switchboxes have no reset.
- `start_i` at cycle t gives `word_ready_o`=1 at t+1.
- A handshake at cycle h puts bit [WORD_W−1] on `program_data_o` with `program_en_o`=1 at h+1. Bit [WORD_W−1−k] appears at h+1+k.
- Each word costs 1 LOAD cycle plus its shift cycles. There is a single bubble per word and no prefetch.
- Without the macro, DONE is the cycle after the last shift bit. With the macro, DONE follows CHAIN_LEN VERIFY cycles.
- `error_o` is registered. It rises in the DONE cycle, together with `done_o`.

## Configuration
- Macro `SB_CFG_READBACK_EN`.
- Defined: VERIFY state and CRC logic are present. CRC-16 (polynomial 0x1021, seed 0xFFFF) is computed over the bits driven in SHIFT and over the `chain_tail_i` bits seen in VERIFY. A mismatch sets `error_o`.
- Undefined: VERIFY and CRC logic are removed, `chain_tail_i` is unused, and `error_o` is tied to 0.

## Structure
- Shared `types` package holds:
  - `sb_cfg_state_t` enum.
  - `SB_CFG_CRC_POLY` and `SB_CFG_CRC_SEED` constants.
  - A helper constant computing `CHAIN_LEN` from `NUM_FU_COLS`, the per-slice `$bits(sb_program_data_t)+1`, and the switchbox count.
- Sub-module `crc16_serial` (clk, rst, clear, en, bit_in, crc_out) is instantiated twice under the macro.

## Test plan
- CHAIN_LEN=40, WORD_W=16, words 0xA5C3, 0x0F0F, 0xFFxx -> exactly 40 `program_en_o` cycles; serial stream is A5C3, 0F0F, FF MSB-first; `done_o` pulses once.
- Host holds `word_valid_i` low for 5 cycles in LOAD -> `program_en_o` stays 0 and no bits are lost; stream resumes on the handshake.
- Macro on, behavioural 40-flop chain model -> after VERIFY, chain contents equal the loaded bits and `error_o`=0.
- Macro on, bit 17 of the chain model flipped during VERIFY -> `error_o`=1 at `done_o` and stays set until the next `start_i`.
- `rst_i` asserted in the 10th SHIFT cycle -> next cycle all outputs are 0 and the FSM is in IDLE; a following load completes normally.
- `start_i` pulsed during SHIFT -> ignored; bit count still 40 and a single `done_o`.

Source files
------------

// File: rtl/sb_config_loader_pkg.sv
// Shared types and constants for the switchbox configuration loader.
// The CRC helpers are used only when SB_CFG_READBACK_EN is defined.
package sb_config_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } sb_cfg_state_t;

    localparam logic [15:0] SB_CFG_CRC_POLY = 16'h1021;
    localparam logic [15:0] SB_CFG_CRC_SEED = 16'hFFFF;

    typedef logic [6:0] sb_program_data_t;

    localparam int NUM_FU_COLS   = 4;
    localparam int SB_PER_COL    = 8;
    // Each slice is its program register plus one output flop.
    localparam int SB_CFG_CHAIN_LEN = NUM_FU_COLS * SB_PER_COL * ($bits(sb_program_data_t) + 1);

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? SB_CFG_CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 accumulator; clear reloads the seed.
module crc16_serial
    import sb_config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc_out <= SB_CFG_CRC_SEED;
        end else if (en) begin
            crc_out <= crc16_step(crc_out, bit_in);
        end
    end

endmodule

// File: rtl/sb_config_loader.sv
// Serializes host words MSB-first into the switchbox scan chain.
// Define SB_CFG_READBACK_EN to add the recirculating CRC readback pass.
module sb_config_loader
    import sb_config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 256,
    parameter int WORD_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              word_valid_i,
    input  logic [WORD_W-1:0] word_data_i,
    output logic              word_ready_o,
    output logic              program_en_o,
    output logic              program_data_o,
    input  logic              chain_tail_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W    = $clog2(NWORDS + 1);

    localparam logic [BIT_W-1:0]  FULL_M1   = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0]  LAST_M1   = BIT_W'(LAST_BITS - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
    localparam logic [WCNT_W-1:0] ALL_WORDS = WCNT_W'(NWORDS);

    sb_cfg_state_t     state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              bit_tc;

    assign bit_tc = (bit_cnt_q == '0);
    assign busy_o = (state_q != IDLE);

`ifdef SB_CFG_READBACK_EN
    localparam logic [BIT_W-1:0] CHAIN_M1 = BIT_W'(CHAIN_LEN - 1);

    logic [15:0] crc_wr, crc_rd;
    logic        crc_clear;
    logic        error_q, error_d;

    assign crc_clear = (state_q == IDLE) && start_i;
    assign error_o   = error_q;

    // One accumulator sees the driven stream, the other the recirculated tail.
    crc16_serial u_crc_wr (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (crc_clear),
        .en      (state_q == SHIFT),
        .bit_in  (program_data_o),
        .crc_out (crc_wr)
    );

    crc16_serial u_crc_rd (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (crc_clear),
        .en      (state_q == VERIFY),
        .bit_in  (chain_tail_i),
        .crc_out (crc_rd)
    );
`else
    logic unused_tail;
    assign unused_tail = chain_tail_i;
    assign error_o     = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        word_cnt_d     = word_cnt_q;
        shreg_d        = shreg_q;
        word_ready_o   = 1'b0;
        program_en_o   = 1'b0;
        program_data_o = 1'b0;
        done_o         = 1'b0;
`ifdef SB_CFG_READBACK_EN
        error_d        = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = LOAD;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
`ifdef SB_CFG_READBACK_EN
                    error_d    = 1'b0;
`endif
                end
            end
            LOAD: begin
                word_ready_o = 1'b1;
                if (word_valid_i) begin
                    shreg_d    = word_data_i;
                    bit_cnt_d  = (word_cnt_q == LAST_WORD) ? LAST_M1 : FULL_M1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                program_en_o   = 1'b1;
                program_data_o = shreg_q[WORD_W-1];
                shreg_d        = shreg_q << 1;
                if (!bit_tc) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (word_cnt_q != ALL_WORDS) begin
                    state_d = LOAD;
                end else begin
`ifdef SB_CFG_READBACK_EN
                    state_d   = VERIFY;
                    bit_cnt_d = CHAIN_M1;
`else
                    state_d   = DONE;
`endif
                end
            end
`ifdef SB_CFG_READBACK_EN
            VERIFY: begin
                program_en_o   = 1'b1;
                program_data_o = chain_tail_i;
                if (bit_tc) begin
                    state_d = DONE;
                    // Fold in the final tail bit so error lands with done.
                    error_d = (crc16_step(crc_rd, chain_tail_i) != crc_wr);
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
`endif
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shreg_q    <= '0;
`ifdef SB_CFG_READBACK_EN
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shreg_q    <= shreg_d;
`ifdef SB_CFG_READBACK_EN
            error_q    <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_sb_config_loader.sv
// Scoreboard bench for sb_config_loader with a behavioural 40-flop chain.
// Readback cases are exercised when SB_CFG_READBACK_EN is defined.
module tb_sb_config_loader;

    localparam int CHAIN_LEN = 40;
    localparam int WORD_W    = 16;
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef SB_CFG_READBACK_EN
    localparam bit RB          = 1'b1;
`else
    localparam bit RB          = 1'b0;
`endif
    localparam int EN_PER_LOAD = RB ? 2 * CHAIN_LEN : CHAIN_LEN;
    // Chain position 17 flipped after 5 verify rotations hits stream bit 27.
    localparam int FLIP_POS    = 17;
    localparam int FLIP_ROT    = 5;
    localparam int FLIP_IDX    = (CHAIN_LEN - 1 - FLIP_POS + FLIP_ROT) % CHAIN_LEN;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic              word_valid_i = 1'b0;
    logic [WORD_W-1:0] word_data_i = '0;
    logic              word_ready_o, program_en_o, program_data_o;
    logic              chain_tail_i, busy_o, done_o, error_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_bits[$];
    bit exp_err[$];
    int en_cnt = 0;
    int done_cnt = 0;
    int flip_at = -1;
    bit last_err = 1'b0;
    bit mon_e;
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] chain_nxt;

    sb_config_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .word_valid_i   (word_valid_i),
        .word_data_i    (word_data_i),
        .word_ready_o   (word_ready_o),
        .program_en_o   (program_en_o),
        .program_data_o (program_data_o),
        .chain_tail_i   (chain_tail_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Switchbox chain: no reset, shifts on program_en.
    assign chain_tail_i = chain[CHAIN_LEN-1];
    always @(posedge clk) begin
        chain_nxt = chain;
        if (program_en_o) chain_nxt = {chain[CHAIN_LEN-2:0], program_data_o};
        if (program_en_o && en_cnt == flip_at) chain_nxt[FLIP_POS] = ~chain_nxt[FLIP_POS];
        chain <= chain_nxt;
    end

    // Monitor: pops expected bits on every enabled cycle and error on done.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (program_en_o) begin
                en_cnt++;
                if (exp_bits.size() == 0) fail_now("unexpected_shift");
                else begin
                    mon_e = exp_bits.pop_front();
                    chk("serial_bit", 64'(program_data_o), 64'(mon_e));
                end
            end else begin
                chk("data_idle_zero", 64'(program_data_o), 64'd0);
            end
            if (done_o) begin
                done_cnt++;
                if (exp_err.size() == 0) fail_now("unexpected_done");
                else begin
                    mon_e = exp_err.pop_front();
                    chk("error_at_done", 64'(error_o), 64'(mon_e));
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int budget;
        budget = 0;
        while (word_ready_o !== 1'b1 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 200) fail_now(name);
    endtask

    task automatic run_load(input bit fixed, input int hold_word, input int hold_len,
                            input bit start_mid, input bit do_flip, input int abort_bit);
        logic [WORD_W-1:0]    words[NWORDS];
        bit                   stream[CHAIN_LEN];
        logic [CHAIN_LEN-1:0] exp_chain;
        int                   base, done_base, budget, fidx;
        for (int w = 0; w < NWORDS; w++) words[w] = WORD_W'($urandom);
        if (fixed) begin
            words[0] = 16'hA5C3;
            words[1] = 16'h0F0F;
            words[2] = {8'hFF, words[2][7:0]};
        end
        fidx = (RB && do_flip) ? FLIP_IDX : -1;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            stream[i] = words[i / WORD_W][WORD_W - 1 - (i % WORD_W)];
            exp_bits.push_back(stream[i]);
        end
        if (RB) for (int i = 0; i < CHAIN_LEN; i++) exp_bits.push_back(stream[i] ^ (i == fidx));
        for (int j = 0; j < CHAIN_LEN; j++)
            exp_chain[j] = stream[CHAIN_LEN - 1 - j] ^ ((CHAIN_LEN - 1 - j) == fidx);
        exp_err.push_back(RB && do_flip);

        chk("error_held_before_start", 64'(error_o), 64'(last_err));
        base      = en_cnt;
        done_base = done_cnt;
        flip_at   = (RB && do_flip) ? base + CHAIN_LEN + FLIP_ROT : -1;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        chk("ready_after_start", 64'(word_ready_o), 64'd1);
        chk("error_cleared_by_start", 64'(error_o), 64'd0);

        for (int w = 0; w < NWORDS; w++) begin
            if (w == hold_word) begin
                wait_ready("hold_wait_timeout");
                for (int c = 0; c < hold_len; c++) begin
                    chk("ready_while_held", 64'(word_ready_o), 64'd1);
                    chk("no_shift_while_held", 64'(program_en_o), 64'd0);
                    @(posedge clk); #1;
                end
            end
            word_data_i  = words[w];
            word_valid_i = 1'b1;
            wait_ready("handshake_timeout");
            @(posedge clk); #1;
            word_valid_i = 1'b0;
            word_data_i  = WORD_W'($urandom);
            if (start_mid && w == 0) begin
                repeat (3) @(posedge clk);
                #1 start_i = 1'b1;
                chk("busy_in_shift", 64'(busy_o), 64'd1);
                @(posedge clk); #1 start_i = 1'b0;
            end
            if (abort_bit > 0 && w == 0) begin
                repeat (abort_bit - 1) @(posedge clk);
                #1 rst_i = 1'b1;
                @(posedge clk); #1;
                chk("abort_en", 64'(program_en_o), 64'd0);
                chk("abort_data", 64'(program_data_o), 64'd0);
                chk("abort_ready", 64'(word_ready_o), 64'd0);
                chk("abort_busy", 64'(busy_o), 64'd0);
                chk("abort_done", 64'(done_o), 64'd0);
                chk("abort_error", 64'(error_o), 64'd0);
                rst_i = 1'b0;
                exp_bits.delete();
                exp_err.delete();
                flip_at  = -1;
                last_err = 1'b0;
                return;
            end
        end

        budget = 0;
        while (done_cnt == done_base && budget < 400) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 400) fail_now("done_timeout");
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 64'(done_cnt - done_base), 64'd1);
        chk("en_cycles", 64'(en_cnt - base), 64'(EN_PER_LOAD));
        chk("chain_contents", 64'(chain), 64'(exp_chain));
        chk("bits_drained", 64'(exp_bits.size()), 64'd0);
        chk("error_sticky", 64'(error_o), 64'(RB && do_flip));
        last_err = RB && do_flip;
        flip_at  = -1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(word_ready_o), 64'd0);
        chk("rst_en", 64'(program_en_o), 64'd0);
        chk("rst_data", 64'(program_data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        rst_i = 1'b0;

        run_load(1'b1, -1, 0, 1'b0, 1'b0, 0);
        run_load(1'b0, 1, 5, 1'b0, 1'b0, 0);
        run_load(1'b0, -1, 0, 1'b1, 1'b0, 0);
`ifdef SB_CFG_READBACK_EN
        run_load(1'b0, -1, 0, 1'b0, 1'b1, 0);
        repeat (4) @(posedge clk);
        #1 chk("error_still_set", 64'(error_o), 64'd1);
`endif
        run_load(1'b0, -1, 0, 1'b0, 1'b0, 0);
        run_load(1'b0, -1, 0, 1'b0, 1'b0, 10);
        run_load(1'b1, -1, 0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 6; k++)
            run_load(1'b0, int'($urandom_range(0, NWORDS - 1)), int'($urandom_range(0, 4)),
                     1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
